// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver (scan-code set 2) producing the 11-bit toggle-strobed key-event word.
// Chain: pin sync -> clock glitch filter -> bit frame FSM -> prefix/byte decoder.
module ps2_key_decoder #(
    parameter int unsigned CLK_HZ     = 12000000,
    parameter int unsigned TIMEOUT_US = 200,
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic        clk_sys,
    input  logic        Reset_n,
    input  logic        ps2_clk_i,
    input  logic        ps2_data_i,
    output logic [10:0] ps2_key_o,
    output logic        frame_err_o
);

    localparam int unsigned TO_CYC   = (CLK_HZ / 1000000) * TIMEOUT_US;
    localparam int unsigned TO_W     = $clog2(TO_CYC + 1);
    localparam int unsigned FLT_W    = $clog2(FILTER_LEN + 1);
    localparam int unsigned SKIP_LEN = 7;
    localparam int unsigned SKIP_W   = 3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } bit_state_t;

    logic             clk_s1, clk_s2, data_s1, data_s2;
    logic             clk_flt, clk_flt_prev;
    logic [FLT_W-1:0] flt_cnt;
    logic             flt_fall;

    bit_state_t       state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             par_q, par_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             byte_vld_q, byte_vld_d;
    logic             flag_clr_q, flag_clr_d;
    logic             err_d;

    logic              ext_q, ext_d, rel_q, rel_d;
    logic [SKIP_W-1:0] skip_q, skip_d;
    logic [10:0]       key_d;

    // Two-flop synchronizers; idle-high presets so reset release sees no edge.
    always_ff @(posedge clk_sys or negedge Reset_n) begin
        if (!Reset_n) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
        end else begin
            clk_s1  <= ps2_clk_i;
            clk_s2  <= clk_s1;
            data_s1 <= ps2_data_i;
            data_s2 <= data_s1;
        end
    end

    // Filtered clock flips on the FILTER_LEN-th consecutive differing sample.
    always_ff @(posedge clk_sys or negedge Reset_n) begin
        if (!Reset_n) begin
            clk_flt      <= 1'b1;
            clk_flt_prev <= 1'b1;
            flt_cnt      <= '0;
        end else begin
            clk_flt_prev <= clk_flt;
            if (clk_s2 != clk_flt) begin
                if (flt_cnt == FLT_W'(FILTER_LEN - 1)) begin
                    clk_flt <= clk_s2;
                    flt_cnt <= '0;
                end else begin
                    flt_cnt <= flt_cnt + FLT_W'(1);
                end
            end else begin
                flt_cnt <= '0;
            end
        end
    end

    assign flt_fall = clk_flt_prev & ~clk_flt;

    always_ff @(posedge clk_sys or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            par_q       <= 1'b0;
            to_cnt_q    <= '0;
            byte_vld_q  <= 1'b0;
            flag_clr_q  <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            par_q       <= par_d;
            to_cnt_q    <= to_cnt_d;
            byte_vld_q  <= byte_vld_d;
            flag_clr_q  <= flag_clr_d;
            frame_err_o <= err_d;
        end
    end

    // Bit-level frame FSM; a falling edge takes priority over a coincident timeout.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        par_d      = par_q;
        to_cnt_d   = to_cnt_q;
        byte_vld_d = 1'b0;
        flag_clr_d = 1'b0;
        err_d      = 1'b0;

        if (state_q == S_IDLE || flt_fall) begin
            to_cnt_d = '0;
        end else if (to_cnt_q != TO_W'(TO_CYC)) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end

        if (flt_fall) begin
            case (state_q)
                S_IDLE: begin
                    if (!data_s2) begin
                        state_d   = S_DATA;
                        bit_cnt_d = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                S_DATA: begin
                    shreg_d   = {data_s2, shreg_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_PARITY;
                    end
                end
                S_PARITY: begin
                    par_d   = data_s2;
                    state_d = S_STOP;
                end
                S_STOP: begin
                    state_d = S_IDLE;
                    if (data_s2 && (^{shreg_q, par_q})) begin
                        byte_vld_d = 1'b1;
                    end else begin
                        err_d      = 1'b1;
                        flag_clr_d = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q != S_IDLE && to_cnt_q == TO_W'(TO_CYC)) begin
            state_d    = S_IDLE;
            err_d      = 1'b1;
            flag_clr_d = 1'b1;
        end
    end

    always_ff @(posedge clk_sys or negedge Reset_n) begin
        if (!Reset_n) begin
            ext_q     <= 1'b0;
            rel_q     <= 1'b0;
            skip_q    <= '0;
            ps2_key_o <= '0;
        end else begin
            ext_q     <= ext_d;
            rel_q     <= rel_d;
            skip_q    <= skip_d;
            ps2_key_o <= key_d;
        end
    end

    // Byte-level prefix decoder: E0/F0 flags, E1 Pause skip, ACK/status bytes ignored.
    always_comb begin
        ext_d  = ext_q;
        rel_d  = rel_q;
        skip_d = skip_q;
        key_d  = ps2_key_o;

        if (flag_clr_q) begin
            ext_d  = 1'b0;
            rel_d  = 1'b0;
            skip_d = '0;
        end else if (byte_vld_q) begin
            if (skip_q != '0) begin
                skip_d = skip_q - SKIP_W'(1);
            end else begin
                case (shreg_q)
                    8'hE0: ext_d  = 1'b1;
                    8'hF0: rel_d  = 1'b1;
                    8'hE1: skip_d = SKIP_W'(SKIP_LEN);
                    8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: begin
                        key_d = ps2_key_o;
                    end
                    default: begin
                        key_d = {~ps2_key_o[10], ~rel_q, ext_q, shreg_q};
                        ext_d = 1'b0;
                        rel_d = 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: directed scenarios then randomized frames
// against a byte-level reference model; a monitor checks every key-word change and error pulse.
module tb_ps2_key_decoder;

    localparam int unsigned FILTER_LEN = 8;

    logic        clk_sys = 1'b0;
    logic        Reset_n = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [10:0] ps2_key_o;
    logic        frame_err_o;

    ps2_key_decoder #(
        .CLK_HZ    (12000000),
        .TIMEOUT_US(200),
        .FILTER_LEN(FILTER_LEN)
    ) dut (
        .clk_sys    (clk_sys),
        .Reset_n    (Reset_n),
        .ps2_clk_i  (ps2_clk),
        .ps2_data_i (ps2_data),
        .ps2_key_o  (ps2_key_o),
        .frame_err_o(frame_err_o)
    );

    always #5 clk_sys = ~clk_sys;

    int          checks = 0;
    int          errors = 0;
    logic [10:0] exp_q[$];
    int          err_exp = 0;
    int          err_seen = 0;
    int          half = 30;

    bit m_ext, m_rel, m_tog;
    int m_skip;

    logic [7:0] disc_tbl[6] = '{8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};

    // Reference model: one received byte as the keyboard protocol defines it.
    task automatic model_byte(input logic [7:0] b);
        if (m_skip > 0) begin
            m_skip--;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_rel = 1'b1;
        end else if (b == 8'hE1) begin
            m_skip = 7;
        end else if (b inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF}) begin
            m_skip = 0;
        end else begin
            m_tog = ~m_tog;
            exp_q.push_back({m_tog, ~m_rel, m_ext, b});
            m_ext = 1'b0;
            m_rel = 1'b0;
        end
    endtask

    task automatic model_frame_err();
        err_exp++;
        m_ext  = 1'b0;
        m_rel  = 1'b0;
        m_skip = 0;
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_ext  = 1'b0;
        m_rel  = 1'b0;
        m_tog  = 1'b0;
        m_skip = 0;
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (half) @(negedge clk_sys);
        ps2_clk = 1'b0;
        repeat (half) @(negedge clk_sys);
        ps2_clk = 1'b1;
    endtask

    // kind: 0 good, 1 bad parity, 2 bad stop; glitch inserts a short clock-low pulse mid-frame.
    task automatic send_frame(input logic [7:0] b, input int kind, input bit glitch);
        logic p;
        p = ~^b;
        if (kind == 1) p = ~p;
        if (kind == 0) model_byte(b);
        else model_frame_err();
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            ps2_bit(b[i]);
            if (glitch && i == 3) begin
                repeat (half / 2) @(negedge clk_sys);
                ps2_clk = 1'b0;
                repeat (FILTER_LEN - 1) @(negedge clk_sys);
                ps2_clk = 1'b1;
                repeat (half / 2) @(negedge clk_sys);
            end
        end
        ps2_bit(p);
        ps2_bit(kind == 2 ? 1'b0 : 1'b1);
        ps2_data = 1'b1;
        repeat (2 * half) @(negedge clk_sys);
    endtask

    task automatic sync_check(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk_sys);
            n++;
        end
        repeat (5) @(negedge clk_sys);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_pending: got %0d events outstanding, required 0", name, exp_q.size());
        end
        checks++;
        if (err_seen != err_exp) begin
            errors++;
            $display("FAIL %s_errcount: got %0d frame_err pulses, required %0d", name, err_seen, err_exp);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if (ps2_key_o !== 11'h000 || frame_err_o !== 1'b0) begin
            errors++;
            $display("FAIL %s: got key=%h err=%b, required key=000 err=0", name, ps2_key_o, frame_err_o);
        end
    endtask

    // Monitor: every change of the key word must match the next scoreboard entry.
    logic [10:0] prev_key = '0;
    logic        prev_err = 1'b0;
    logic [10:0] exp_w;
    always @(negedge clk_sys) begin
        if (!Reset_n) begin
            prev_key = '0;
            prev_err = 1'b0;
        end else begin
            if (ps2_key_o !== prev_key) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: got %h, required no event", ps2_key_o);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (ps2_key_o !== exp_w) begin
                        errors++;
                        $display("FAIL event: got %h, required %h", ps2_key_o, exp_w);
                    end
                end
                prev_key = ps2_key_o;
            end
            if (frame_err_o === 1'b1) begin
                err_seen++;
                checks++;
                if (prev_err) begin
                    errors++;
                    $display("FAIL err_pulse_width: got high 2+ cycles, required 1-cycle pulse");
                end
            end
            prev_err = frame_err_o;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got no completion, required finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] b;
        int         r;
        int         kind;

        model_reset();
        repeat (5) @(negedge clk_sys);
        check_idle_outputs("reset_held");
        Reset_n = 1'b1;
        repeat (5) @(negedge clk_sys);
        check_idle_outputs("reset_released");

        send_frame(8'h1C, 0, 1'b0);
        sync_check("make_1c");
        send_frame(8'hF0, 0, 1'b0);
        send_frame(8'h1C, 0, 1'b0);
        sync_check("break_1c");
        send_frame(8'hE0, 0, 1'b0);
        send_frame(8'h75, 0, 1'b0);
        send_frame(8'h29, 0, 1'b0);
        sync_check("ext_75_then_29");

        send_frame(8'h1C, 1, 1'b0);
        sync_check("bad_parity");
        send_frame(8'h1C, 0, 1'b0);
        sync_check("after_parity");
        send_frame(8'hE0, 0, 1'b0);
        send_frame(8'h5A, 2, 1'b0);
        send_frame(8'h5A, 0, 1'b0);
        sync_check("bad_stop_clears_ext");

        // Start error: a clock pulse with data high while idle.
        err_exp++;
        ps2_bit(1'b1);
        repeat (2 * half) @(negedge clk_sys);
        sync_check("start_err");

        // Timeout: start plus 4 data bits, then 250 us of idle clock.
        model_frame_err();
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        ps2_data = 1'b1;
        repeat (3000) @(negedge clk_sys);
        sync_check("timeout");
        send_frame(8'h29, 0, 1'b0);
        sync_check("after_timeout");

        send_frame(8'h4B, 0, 1'b1);
        sync_check("clk_glitch");

        // Reset in the middle of a frame.
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        Reset_n  = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        model_reset();
        repeat (5) @(negedge clk_sys);
        check_idle_outputs("midframe_reset");
        Reset_n = 1'b1;
        repeat (5) @(negedge clk_sys);
        check_idle_outputs("after_midframe_reset");
        send_frame(8'h1C, 0, 1'b0);
        sync_check("after_reset_frame");

        for (int n = 0; n < 50; n++) begin
            half = int'($urandom_range(15, 40));
            r    = int'($urandom_range(0, 9));
            case (r)
                0: b = 8'hE0;
                1: b = 8'hF0;
                2: b = ($urandom_range(0, 2) == 0) ? 8'hE1 : 8'hF0;
                3: b = disc_tbl[$urandom_range(0, 5)];
                default: b = 8'($urandom);
            endcase
            r = int'($urandom_range(0, 15));
            kind = (r == 0) ? 1 : (r == 1) ? 2 : 0;
            send_frame(b, kind, 1'b0);
        end
        sync_check("random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
